// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: valid/ready operand transfer in, registered result and flags out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic             OverFlow;
  logic             Zero;
  logic             Negative;

  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, Result, Carry, OverFlow, Zero, Negative
  );

  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, Result, Carry, OverFlow, Zero, Negative
  );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with flags and a restoring unsigned divider (1 quotient bit/cycle).
// Define ALU_DIV_EN to build the divider; otherwise op 011 completes at once flagged unsupported.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
`ifdef ALU_DIV_EN
    DIV  = 2'd2,
`endif
    IDLE = 2'd0,
    HOLD = 2'd1
  } state_e;

  typedef enum logic [2:0] {
    OP_SUB = 3'b000,
    OP_ADD = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_OR  = 3'b111
  } op_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, zero_q, neg_q;

  logic             in_ready_w, accept;
  op_e              op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]   sum_w, dif_w, shl_w, shr_w;
  logic [2*WIDTH-1:0] prod_w;
  logic [WIDTH-1:0] res_d;
  logic             carry_d, ovf_d;

  assign in_ready_w = !rst && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
  assign accept     = bus.in_valid && in_ready_w;

  assign op     = op_e'(bus.ALUControl);
  assign shamt  = bus.B[SHAMT_W-1:0];
  assign sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
  assign dif_w  = {1'b0, bus.A} - {1'b0, bus.B};
  assign prod_w = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
  // One guard bit on each side captures the last bit shifted out (stays 0 for shamt=0)
  assign shl_w  = {1'b0, bus.A} << shamt;
  assign shr_w  = {bus.A, 1'b0} >> shamt;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge, div_start_d;
  logic [WIDTH-1:0]   rem_nx, quo_nx;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge = rem_sh >= {1'b0, dvs_q};
  assign rem_nx = rem_ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], rem_ge};
`endif

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
`ifdef ALU_DIV_EN
    div_start_d = 1'b0;
`endif
    case (op)
      OP_SUB: begin
        res_d   = dif_w[WIDTH-1:0];
        carry_d = ~dif_w[WIDTH];
        ovf_d   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_ADD: begin
        res_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_MUL: begin
        res_d   = prod_w[WIDTH-1:0];
        carry_d = |prod_w[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
`ifdef ALU_DIV_EN
        if (bus.B == '0) begin
          res_d = '1;
          ovf_d = 1'b1;
        end else begin
          div_start_d = 1'b1;
        end
`else
        ovf_d = 1'b1;
`endif
      end
      OP_AND: res_d = bus.A & bus.B;
      OP_SHL: begin
        res_d   = shl_w[WIDTH-1:0];
        carry_d = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_d   = shr_w[WIDTH:1];
        carry_d = shr_w[0];
      end
      OP_OR:  res_d = bus.A | bus.B;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`ifdef ALU_DIV_EN
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            result_q    <= res_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= (res_d == '0);
            neg_q       <= res_d[WIDTH-1];
`ifdef ALU_DIV_EN
            // A real divide overrides the single-cycle load above and starts iterating
            if (div_start_d) begin
              state_q     <= DIV;
              out_valid_q <= 1'b0;
              rem_q       <= '0;
              quo_q       <= bus.A;
              dvs_q       <= bus.B;
              cnt_q       <= '0;
            end
`endif
          end else if ((state_q == HOLD) && bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_DIV_EN
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            result_q    <= quo_nx;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= (quo_nx == '0);
            neg_q       <= quo_nx[WIDTH-1];
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Carry     = carry_q;
  assign bus.OverFlow  = ovf_q;
  assign bus.Zero      = zero_q;
  assign bus.Negative  = neg_q;
endmodule
